fft3d_xpose_buf: RTL and testbench
==================================

Name: fft3d_xpose_buf

Overview:
Parametrised corner-turn buffer between 3D-FFT stages. It holds one D×D×D cube split across LANES banks along the row axis, and generates its own write and read addresses. It accepts a frame in write order and emits it in a transposed order selected per frame, using valid/ready handshakes on both sides. It replaces fixed 2-lane, externally-addressed buffer control.

Parameters:
CUBIC_D, 96, cube edge D; must be divisible by LANES
LANES, 2, samples per beat = bank count; power of 2, at least 1
DATA_W, 64, bits per sample (complex re/im packed)
BEATS, CUBIC_D**3/LANES, derived: beats per frame = per-bank depth
AW, $clog2(BEATS), derived: bank address width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
mode  in  1  read order for the next drain; sampled on the FILL->DRAIN transition
in_valid  in  1  input beat valid
in_ready  out  1  high only in FILL
in_data  in  LANES*DATA_W  lane l = row LANES*g+l
in_last  in  1  asserted by source on the final write beat
out_valid  out  1  output beat valid
out_ready  in  1  sink ready
out_data  out  LANES*DATA_W  lane l = row LANES*g+l
out_last  out  1  high with the final drain beat
frame_done  out  1  one-cycle pulse after the final drain handshake
frame_err  out  1  sticky; in_last position mismatch

Behaviour:
- Coordinates: g = row group (0..D/LANES-1), c = col, d = dep. Element (row=LANES*g+l, c, d) lives in bank l at address g*D*D + d*D + c.
- Arithmetic: counters are $clog2(D) bits each. Address uses an unsigned multiply-add truncated to AW bits.
- Write order: c fastest, then d, then g. One beat per in_valid&&in_ready.
- Read order for mode 0: g fastest, then c, then d. Read order for mode 1: g fastest, then d, then c. The latched mode holds for the whole drain.
- State machine FILL:
  - in_ready=1.
  - Each handshake writes all LANES banks at the same address, then advances the write counters.
  - After beat BEATS-1 is accepted, go to DRAIN, clear the write counters and latch mode.
- State machine DRAIN:
  - in_ready=0.
  - A read is issued when (!out_valid || out_ready) and read beats remain.
  - Bank read latency is 1 cycle. out_valid sets the cycle after an issue and clears when out_ready is high with no new issue.
  - When stalled, no read is issued, so the bank output holds. out_data is stable while out_valid && !out_ready.
  - Sustained throughput is 1 beat/cycle when out_ready stays high.
  - out_last accompanies the beat at read index BEATS-1.
  - On the out_last handshake: pulse frame_done, clear the read counters, return to FILL.
- frame_err:
  - Sets when in_last is high on an accepted beat other than BEATS-1.
  - Sets when in_last is low on beat BEATS-1.
  - The frame still completes on the count. Only reset clears frame_err.
- Reset values: state FILL, all counters 0, latched mode 0, in_ready 1 (the cycle after reset), out_valid 0, out_last 0, frame_done 0, frame_err 0, out_data 0.
- Reset mid-frame: counters and state reset. Bank contents are not cleared, and the partial frame is discarded.
- in_valid during DRAIN is ignored (no write). Changing mode during DRAIN has no effect until the next transition.
- Simultaneous events: a final write handshake with mode toggling samples the mode value of that same cycle.

Decomposition:
- Shared package fft3d_pkg holds:
  - localparams for D, LANES, DATA_W and the derived BEATS/AW;
  - state encoding FILL=1'b0, DRAIN=1'b1;
  - mode encoding XP_CD=0, XP_DC=1.
- One sub-module, fft3d_xpose_bank: a single-port synchronous RAM (DATA_W × BEATS, write-enable, read-enable, registered read, output holds when not enabled), instantiated LANES times.
- Address generation and the FSM stay in the top level.

Test Plan:
Bench parameters: D=4, LANES=2, BEATS=32. Sample value = row*16 + dep*4 + col. Sources are fed in write order.
- Mode 0, out_ready always 1: first drain beats {0,16}, {32,48}, {1,17}. out_last on beat 31 = {63-16=47, 63}, i.e. rows 2,3 col3 dep3 = {47,63}. frame_done 1 cycle after.
- Mode 1: drain beats {0,16}, {32,48}, {4,20}, {36,52}, {8,24}.
- Random out_ready stalls (50%): out_data is held while stalled, no beat is lost or duplicated, and 32 beats are received in mode-0 order.
- in_last asserted on beat 10: frame_err=1 and stays 1. The drain still produces 32 correct beats.
- Reset asserted at write beat 12: in_ready=1, out_valid=0 the next cycle. A new full frame drains correctly, and beat 0 = {0,16}.
- Back-to-back frames, mode 0 then mode 1: in_ready=0 throughout the drain. The second frame reflects its own mode, and frame_done pulses twice.

Source files
------------

// File: rtl/fft3d_pkg.sv
// Shared definitions for the 3D-FFT corner-turn buffer: default geometry,
// FSM and read-order encodings, and the bank address helper.
package fft3d_pkg;

    localparam int PKG_CUBIC_D = 96;
    localparam int PKG_LANES   = 2;
    localparam int PKG_DATA_W  = 64;
    localparam int PKG_BEATS   = (PKG_CUBIC_D * PKG_CUBIC_D * PKG_CUBIC_D) / PKG_LANES;
    localparam int PKG_AW      = $clog2(PKG_BEATS);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } xp_state_e;

    typedef enum logic {
        XP_CD = 1'b0,   // drain g fastest, then col, then dep
        XP_DC = 1'b1    // drain g fastest, then dep, then col
    } xp_mode_e;

    // Bank address of element (group g, dep d, col c) for a cube of edge dim.
    // Callers truncate the result to the bank address width.
    function automatic logic [31:0] cube_addr(
        input logic [31:0] g,
        input logic [31:0] d,
        input logic [31:0] c,
        input logic [31:0] dim
    );
        return (g * dim * dim) + (d * dim) + c;
    endfunction

endpackage

// File: rtl/fft3d_xpose_bank.sv
// One bank of the corner-turn buffer: single-port synchronous RAM with a
// registered read port that holds its value when no read is enabled.
module fft3d_xpose_bank
    import fft3d_pkg::*;
#(
    parameter int DATA_W = PKG_DATA_W,
    parameter int BEATS  = PKG_BEATS,
    parameter int AW     = PKG_AW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [BEATS];
    logic [DATA_W-1:0] rdata_r;

    // Storage array write; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read port; holds the last read word while re is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/fft3d_xpose_buf.sv
// Corner-turn buffer between 3D-FFT stages. Accepts one D x D x D cube in
// write order (col, dep, group) and drains it in a per-frame transposed
// order, generating all bank addresses internally.
module fft3d_xpose_buf
    import fft3d_pkg::*;
#(
    parameter int CUBIC_D = PKG_CUBIC_D,
    parameter int LANES   = PKG_LANES,
    parameter int DATA_W  = PKG_DATA_W,
    parameter int BEATS   = (CUBIC_D * CUBIC_D * CUBIC_D) / LANES,
    parameter int AW      = $clog2(BEATS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    out_last,
    output logic                    frame_done,
    output logic                    frame_err
);

    localparam int CW     = $clog2(CUBIC_D);
    localparam int GROUPS = CUBIC_D / LANES;

    localparam logic [CW-1:0] C_MAX = CW'(CUBIC_D - 1);
    localparam logic [CW-1:0] G_MAX = CW'(GROUPS - 1);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_ZERO = CW'(0);

    xp_state_e state_r;
    xp_state_e state_s;
    xp_mode_e  mode_r;

    logic [CW-1:0] wr_col_r;
    logic [CW-1:0] wr_dep_r;
    logic [CW-1:0] wr_grp_r;
    logic [CW-1:0] rd_col_r;
    logic [CW-1:0] rd_dep_r;
    logic [CW-1:0] rd_grp_r;

    logic rd_all_r;
    logic out_valid_r;
    logic out_last_r;
    logic frame_done_r;
    logic frame_err_r;

    logic          wr_hs_s;
    logic          wr_last_s;
    logic          rd_issue_s;
    logic          rd_last_s;
    logic          out_hs_last_s;
    logic [AW-1:0] wr_addr_s;
    logic [AW-1:0] rd_addr_s;
    logic [AW-1:0] bank_addr_s;

    assign wr_hs_s    = (state_r == FILL) && in_valid;
    assign wr_last_s  = (wr_col_r == C_MAX) && (wr_dep_r == C_MAX) && (wr_grp_r == G_MAX);
    assign rd_issue_s = (state_r == DRAIN) && (!out_valid_r || out_ready) && !rd_all_r;
    assign rd_last_s  = (rd_col_r == C_MAX) && (rd_dep_r == C_MAX) && (rd_grp_r == G_MAX);
    assign out_hs_last_s = out_valid_r && out_ready && out_last_r;

    assign wr_addr_s = AW'(cube_addr(32'(wr_grp_r), 32'(wr_dep_r), 32'(wr_col_r), 32'(CUBIC_D)));
    assign rd_addr_s = AW'(cube_addr(32'(rd_grp_r), 32'(rd_dep_r), 32'(rd_col_r), 32'(CUBIC_D)));

    // Single-port banks: the write address owns the port in FILL, the read address in DRAIN.
    always_comb begin
        bank_addr_s = rd_addr_s;
        if (state_r == FILL) begin
            bank_addr_s = wr_addr_s;
        end else begin
            bank_addr_s = rd_addr_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= FILL;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: leave FILL on the final write, leave DRAIN on the last-beat handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            FILL: begin
                if (wr_hs_s && wr_last_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = FILL;
                end
            end
            DRAIN: begin
                if (out_hs_last_s) begin
                    state_s = FILL;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: state_s = FILL;
        endcase
    end

    // Read order latched at the FILL->DRAIN transition, using that cycle's mode input.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_r <= XP_CD;
        end else if (wr_hs_s && wr_last_s) begin
            mode_r <= xp_mode_e'(mode);
        end
    end

    // Write counters: col fastest, then dep, then group; cleared after the final beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_col_r <= C_ZERO;
            wr_dep_r <= C_ZERO;
            wr_grp_r <= C_ZERO;
        end else if (wr_hs_s) begin
            if (wr_last_s) begin
                wr_col_r <= C_ZERO;
                wr_dep_r <= C_ZERO;
                wr_grp_r <= C_ZERO;
            end else if (wr_col_r == C_MAX) begin
                wr_col_r <= C_ZERO;
                if (wr_dep_r == C_MAX) begin
                    wr_dep_r <= C_ZERO;
                    wr_grp_r <= wr_grp_r + C_ONE;
                end else begin
                    wr_dep_r <= wr_dep_r + C_ONE;
                end
            end else begin
                wr_col_r <= wr_col_r + C_ONE;
            end
        end
    end

    // Read counters: group fastest; col/dep nesting follows the latched mode.
    always_ff @(posedge clock) begin
        if (reset || out_hs_last_s) begin
            rd_col_r <= C_ZERO;
            rd_dep_r <= C_ZERO;
            rd_grp_r <= C_ZERO;
        end else if (rd_issue_s) begin
            if (rd_grp_r != G_MAX) begin
                rd_grp_r <= rd_grp_r + C_ONE;
            end else begin
                rd_grp_r <= C_ZERO;
                if (mode_r == XP_CD) begin
                    if (rd_col_r == C_MAX) begin
                        rd_col_r <= C_ZERO;
                        rd_dep_r <= (rd_dep_r == C_MAX) ? C_ZERO : (rd_dep_r + C_ONE);
                    end else begin
                        rd_col_r <= rd_col_r + C_ONE;
                    end
                end else begin
                    if (rd_dep_r == C_MAX) begin
                        rd_dep_r <= C_ZERO;
                        rd_col_r <= (rd_col_r == C_MAX) ? C_ZERO : (rd_col_r + C_ONE);
                    end else begin
                        rd_dep_r <= rd_dep_r + C_ONE;
                    end
                end
            end
        end
    end

    // Marks that every read of the frame has been issued, so no further reads start.
    always_ff @(posedge clock) begin
        if (reset || out_hs_last_s) begin
            rd_all_r <= 1'b0;
        end else if (rd_issue_s && rd_last_s) begin
            rd_all_r <= 1'b1;
        end
    end

    // Output beat flags track the one-cycle bank read latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (rd_issue_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= rd_last_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    // One-cycle completion pulse following the last-beat handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= out_hs_last_s;
        end
    end

    // Sticky framing error: in_last disagrees with the beat count.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_err_r <= 1'b0;
        end else if (wr_hs_s && (in_last != wr_last_s)) begin
            frame_err_r <= 1'b1;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_bank
        fft3d_xpose_bank #(
            .DATA_W (DATA_W),
            .BEATS  (BEATS),
            .AW     (AW)
        ) u_bank (
            .clock  (clock),
            .reset  (reset),
            .we     (wr_hs_s),
            .re     (rd_issue_s),
            .addr   (bank_addr_s),
            .wdata  (in_data[l*DATA_W +: DATA_W]),
            .rdata  (out_data[l*DATA_W +: DATA_W])
        );
    end

    assign in_ready   = (state_r == FILL);
    assign out_valid  = out_valid_r;
    assign out_last   = out_last_r;
    assign frame_done = frame_done_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_fft3d_xpose_buf.sv
// Self-checking bench for fft3d_xpose_buf with D=4, LANES=2 (32 beats/frame).
// A cube-level model records written elements by (row, col, dep) and derives
// the drain sequence from the mode's loop order.
module tb_fft3d_xpose_buf;

    localparam int D  = 4;
    localparam int L  = 2;
    localparam int W  = 16;
    localparam int NB = 32;

    logic          clock;
    logic          reset;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [L*W-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [L*W-1:0] out_data;
    logic          out_last;
    logic          frame_done;
    logic          frame_err;

    fft3d_xpose_buf #(.CUBIC_D(D), .LANES(L), .DATA_W(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    logic [15:0] cube [4][4][4];   // [row][col][dep]
    logic [32:0] exp_q [$];        // {last, lane1, lane0}
    logic [32:0] rx_q  [$];
    bit          drain_m   = 1'b0;
    bit          done_exp_m = 1'b0;
    bit          err_m     = 1'b0;
    int          w_m       = 0;
    int          done_cnt  = 0;
    int          drain_cnt = 0;
    int          ready_pct = 100;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pattern(input int w, input int salt);
        int g, d, c;
        logic [15:0] v0, v1;
        g  = w / 16;
        d  = (w / 4) % 4;
        c  = w % 4;
        v0 = 16'(((2 * g) * 16) + d * 4 + c + salt * 64);
        v1 = 16'(((2 * g + 1) * 16) + d * 4 + c + salt * 64);
        return {v1, v0};
    endfunction

    // sink readiness, re-drawn each cycle
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            out_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // per-cycle compare against the cube model
    initial begin
        bit was_drain;
        logic [32:0] e;
        forever begin
            @(negedge clock);
            was_drain = drain_m;
            if (drain_m) drain_cnt++;
            check("in_ready", in_ready, !drain_m);
            check("frame_done", frame_done, done_exp_m);
            check("frame_err", frame_err, err_m);
            if (frame_done) done_cnt++;
            if (!drain_m) check("idle_out_valid", out_valid, 1'b0);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", {out_last, out_data}, {1'b0, prev_data} | ({32'd0, out_last} << 32));
                check("stall_data_only", out_data, prev_data);
            end
            done_exp_m = 1'b0;
            if (reset) begin
                drain_m = 1'b0;
                err_m = 1'b0;
                w_m = 0;
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                if (out_valid && out_ready) begin
                    rx_q.push_back({out_last, out_data});
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_beat: got %0h expected no beat", {out_last, out_data});
                    end else begin
                        e = exp_q.pop_front();
                        check("out_beat", {out_last, out_data}, e);
                        if (e[32]) begin
                            drain_m = 1'b0;
                            done_exp_m = 1'b1;
                        end
                    end
                end
                if (in_valid && !was_drain) begin
                    for (int l = 0; l < L; l++)
                        cube[2 * (w_m / 16) + l][w_m % 4][(w_m / 4) % 4] = in_data[l*W +: W];
                    if (in_last != (w_m == NB - 1)) err_m = 1'b1;
                    if (w_m == NB - 1) begin
                        for (int k = 0; k < NB; k++) begin
                            int g, inner, outer, c, d;
                            g = k % 2;
                            inner = (k / 2) % 4;
                            outer = k / 8;
                            if (mode == 1'b0) begin c = inner; d = outer; end
                            else begin d = inner; c = outer; end
                            exp_q.push_back({(k == NB - 1), cube[2*g+1][c][d], cube[2*g][c][d]});
                        end
                        drain_m = 1'b1;
                        w_m = 0;
                    end else begin
                        w_m++;
                    end
                end
            end
        end
    end

    // Feed one frame in write order with random gaps; abort_at >= 0 resets at that beat.
    task automatic send_frame(input int salt, input bit m, input int err_beat, input int abort_at);
        int w = 0;
        while (w < NB) begin
            @(posedge clock);
            #1;
            if (w == abort_at) begin
                in_valid = 1'b0;
                in_last = 1'b0;
                reset = 1'b1;
                @(posedge clock);
                #1;
                reset = 1'b0;
                return;
            end
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_last = 1'b0;
                mode = 1'($urandom_range(0, 1));
                continue;
            end
            in_valid = 1'b1;
            in_data = pattern(w, salt);
            in_last = (w == NB - 1) || (w == err_beat);
            mode = (w == NB - 1) ? m : 1'($urandom_range(0, 1));
            @(negedge clock);
            w++;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    // Wait for the frame_done count to reach target; junk input and mode toggles during drain.
    task automatic wait_done(input int target);
        int cyc = 0;
        while (done_cnt < target && cyc < 2000) begin
            @(posedge clock);
            #1;
            if (drain_m && exp_q.size() > 2) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data = $urandom;
                mode = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        check("drain_timeout", done_cnt, target);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        mode = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);

        // mode 0, sink always ready
        ready_pct = 100;
        rx_q.delete();
        drain_cnt = 0;
        send_frame(0, 1'b0, -1, -1);
        wait_done(1);
        check("m0_count", rx_q.size(), 32);
        check("m0_beat0", rx_q[0], {1'b0, 16'd16, 16'd0});
        check("m0_beat1", rx_q[1], {1'b0, 16'd48, 16'd32});
        check("m0_beat2", rx_q[2], {1'b0, 16'd17, 16'd1});
        check("m0_beat31", rx_q[31], {1'b1, 16'd63, 16'd47});
        check("m0_drain_cycles", drain_cnt, 33);

        // mode 1, back to back
        rx_q.delete();
        send_frame(0, 1'b1, -1, -1);
        wait_done(2);
        check("m1_beat0", rx_q[0], {1'b0, 16'd16, 16'd0});
        check("m1_beat1", rx_q[1], {1'b0, 16'd48, 16'd32});
        check("m1_beat2", rx_q[2], {1'b0, 16'd20, 16'd4});
        check("m1_beat3", rx_q[3], {1'b0, 16'd52, 16'd36});
        check("m1_beat4", rx_q[4], {1'b0, 16'd24, 16'd8});
        check("two_done", done_cnt, 2);

        // 50% sink stalls
        ready_pct = 50;
        rx_q.delete();
        send_frame($urandom_range(0, 1023), 1'b0, -1, -1);
        wait_done(3);
        check("stall_count", rx_q.size(), 32);

        // early in_last on beat 10
        rx_q.delete();
        send_frame($urandom_range(0, 1023), 1'($urandom_range(0, 1)), 10, -1);
        wait_done(4);
        check("err_set", frame_err, 1'b1);
        check("err_count", rx_q.size(), 32);
        send_frame($urandom_range(0, 1023), 1'($urandom_range(0, 1)), -1, -1);
        wait_done(5);
        check("err_sticky", frame_err, 1'b1);

        // reset in the middle of a fill
        send_frame(7, 1'b0, -1, 12);
        @(negedge clock);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_err", frame_err, 1'b0);
        ready_pct = 100;
        rx_q.delete();
        send_frame(0, 1'b0, -1, -1);
        wait_done(6);
        check("after_rst_beat0", rx_q[0], {1'b0, 16'd16, 16'd0});
        check("after_rst_count", rx_q.size(), 32);

        // random frames
        for (int i = 0; i < 6; i++) begin
            ready_pct = $urandom_range(20, 100);
            rx_q.delete();
            send_frame($urandom_range(0, 1023), 1'($urandom_range(0, 1)), -1, -1);
            wait_done(7 + i);
            check("rand_count", rx_q.size(), 32);
        end

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
